// File: rtl/reg_text_writer.sv
// Formats a snapshot of NUM_REGS registers as "X:0xHHHH" text lines and streams
// them into a character RAM write port, one character per accepted cycle.
module reg_text_writer #(
  parameter int NUM_REGS       = 4,
  parameter int DATA_W         = 16,
  parameter int FIRST_LINE     = 3,
  parameter int LINE_STEP      = 2,
  parameter int COL_START      = 0,
  parameter int LINE_LEN       = 12,
  parameter bit SKIP_UNCHANGED = 1'b0
) (
  input  logic                         pixel_clock,
  input  logic                         reset,
  input  logic                         refresh,
  input  logic [NUM_REGS*DATA_W-1:0]   reg_data,
  output logic [13:0]                  wr_addr,
  output logic [7:0]                   wr_data,
  output logic                         wr_en,
  input  logic                         wr_ready,
  output logic                         busy,
  output logic                         done
);

  localparam int NDIG = (DATA_W + 3) / 4;
  localparam int PW   = NDIG * 4;
  localparam int VW   = NUM_REGS * DATA_W;
  localparam int KW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_DONE} state_t;

  state_t          state_reg, state_next;
  logic [KW-1:0]   k_reg, k_next;
  logic [6:0]      c_reg, c_next;
  logic            pending_reg, pending_next;
  logic [VW-1:0]   snapshot_reg;
  logic [VW-1:0]   shadow_reg;
  logic            start;
  logic            xfer;
  logic            last_char;
  logic [KW:0]     hit;

  // First line index >= start that must be written; MSB flags that one exists.
  // Searching combinationally lets skipped lines cost no cycles at all.
  function automatic logic [KW:0] find_line(input logic [VW-1:0] vals,
                                            input logic [VW-1:0] shad,
                                            input int            first);
    logic [KW:0] r;
    r = '0;
    for (int j = NUM_REGS - 1; j >= 0; j--) begin
      if (j >= first && (!SKIP_UNCHANGED ||
          vals[j*DATA_W +: DATA_W] != shad[j*DATA_W +: DATA_W]))
        r = {1'b1, KW'(j)};
    end
    return r;
  endfunction

  always_comb begin
    state_next   = state_reg;
    k_next       = k_reg;
    c_next       = c_reg;
    pending_next = pending_reg;
    start        = 1'b0;
    hit          = '0;
    xfer         = (state_reg == ST_WRITE) && wr_ready;
    last_char    = (c_reg == 7'(LINE_LEN - 1));
    case (state_reg)
      ST_IDLE: begin
        if (refresh || pending_reg) begin
          start        = 1'b1;
          pending_next = 1'b0;
          hit          = find_line(reg_data, shadow_reg, 0);
          c_next       = '0;
          if (hit[KW]) begin
            k_next     = hit[KW-1:0];
            state_next = ST_WRITE;
          end else begin
            state_next = ST_DONE;
          end
        end
      end
      ST_WRITE: begin
        pending_next = pending_reg | refresh;
        if (xfer) begin
          if (last_char) begin
            hit    = find_line(snapshot_reg, shadow_reg, int'(k_reg) + 1);
            c_next = '0;
            if (hit[KW]) k_next = hit[KW-1:0];
            else         state_next = ST_DONE;
          end else begin
            c_next = c_reg + 7'd1;
          end
        end
      end
      ST_DONE: begin
        pending_next = pending_reg | refresh;
        state_next   = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge pixel_clock or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      k_reg        <= '0;
      c_reg        <= '0;
      pending_reg  <= 1'b0;
      snapshot_reg <= '0;
      shadow_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      k_reg       <= k_next;
      c_reg       <= c_next;
      pending_reg <= pending_next;
      if (start) snapshot_reg <= reg_data;
      if (xfer && last_char)
        shadow_reg[k_reg*DATA_W +: DATA_W] <= snapshot_reg[k_reg*DATA_W +: DATA_W];
    end
  end

  logic [PW-1:0] cur_val;
  logic [3:0]    nib;
  logic [7:0]    ch;

  always_comb begin
    wr_en   = (state_reg == ST_WRITE);
    busy    = (state_reg != ST_IDLE);
    done    = (state_reg == ST_DONE);
    cur_val = PW'(snapshot_reg[k_reg*DATA_W +: DATA_W]);
    nib     = '0;
    ch      = 8'h20;
    case (c_reg)
      7'd0:    ch = 8'h41 + 8'(k_reg);
      7'd1:    ch = 8'h3A;
      7'd2:    ch = 8'h30;
      7'd3:    ch = 8'h78;
      default: begin
        if (int'(c_reg) < 4 + NDIG) begin
          nib = 4'(cur_val >> (4 * (NDIG + 3 - int'(c_reg))));
          ch  = (nib < 4'd10) ? (8'h30 + 8'(nib)) : (8'h37 + 8'(nib));
        end
      end
    endcase
    wr_data = wr_en ? ch : 8'h00;
    wr_addr = wr_en ? {7'(FIRST_LINE + int'(k_reg) * LINE_STEP), 7'(COL_START + int'(c_reg))}
                    : 14'h0000;
  end

endmodule

// File: tb/tb_reg_text_writer.sv
// Directed bench: default instance for timing/handshake/overlap/reset,
// plus a skip-unchanged instance and a 10-bit-data instance.
module tb_reg_text_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  // default instance
  logic        ref_d = 1'b0, ready_d = 1'b1;
  logic [63:0] data_d = 64'h0;
  logic [13:0] addr_d;
  logic [7:0]  wdata_d;
  logic        en_d, busy_d, done_d;

  // skip-unchanged instance
  logic        ref_s = 1'b0;
  logic [63:0] data_s = 64'h0;
  logic [13:0] addr_s;
  logic [7:0]  wdata_s;
  logic        en_s, busy_s, done_s;

  // 10-bit instance
  logic        ref_w = 1'b0;
  logic [39:0] data_w = 40'h0;
  logic [13:0] addr_w;
  logic [7:0]  wdata_w;
  logic        en_w, busy_w, done_w;

  reg_text_writer dut (
    .pixel_clock(clk), .reset(rst_n), .refresh(ref_d), .reg_data(data_d),
    .wr_addr(addr_d), .wr_data(wdata_d), .wr_en(en_d), .wr_ready(ready_d),
    .busy(busy_d), .done(done_d));

  reg_text_writer #(.SKIP_UNCHANGED(1'b1)) dut_skip (
    .pixel_clock(clk), .reset(rst_n), .refresh(ref_s), .reg_data(data_s),
    .wr_addr(addr_s), .wr_data(wdata_s), .wr_en(en_s), .wr_ready(1'b1),
    .busy(busy_s), .done(done_s));

  reg_text_writer #(.DATA_W(10)) dut_w10 (
    .pixel_clock(clk), .reset(rst_n), .refresh(ref_w), .reg_data(data_w),
    .wr_addr(addr_w), .wr_data(wdata_w), .wr_en(en_w), .wr_ready(1'b1),
    .busy(busy_w), .done(done_w));

  int          sel = 1;
  logic        m_en, m_done;
  logic [13:0] m_addr;
  logic [7:0]  m_data;
  assign m_en   = (sel == 1) ? en_s    : en_w;
  assign m_done = (sel == 1) ? done_s  : done_w;
  assign m_addr = (sel == 1) ? addr_s  : addr_w;
  assign m_data = (sel == 1) ? wdata_s : wdata_w;

  string       exp_line[4];
  logic [13:0] cap_addr[64];
  logic [7:0]  cap_data[64];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Walks one full pass of the default instance starting in its first write cycle.
  task automatic do_pass(input int stall_idx, input bit pulses);
    int n;
    logic [13:0] a;
    logic [7:0]  d;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 12; c++) begin
        a = {7'(3 + 2 * k), 7'(c)};
        d = exp_line[k].getc(c);
        if (k * 12 + c == stall_idx) begin
          ready_d = 1'b0;
          for (int s = 0; s < 3; s++) begin
            check("stall_en", 32'(en_d), 32'd1);
            check("stall_addr", 32'(addr_d), 32'(a));
            check("stall_data", 32'(wdata_d), 32'(d));
            tick();
          end
          ready_d = 1'b1;
        end
        check("wr_en", 32'(en_d), 32'd1);
        check("wr_addr", 32'(addr_d), 32'(a));
        check("wr_data", 32'(wdata_d), 32'(d));
        if (pulses && (k * 12 + c == 5 || k * 12 + c == 20 || k * 12 + c == 30)) ref_d = 1'b1;
        if (pulses && k * 12 + c == 25) data_d[15:0] = 16'hBEEF;
        if (en_d && ready_d) n++;
        tick();
        ref_d = 1'b0;
      end
    end
    check("transfers", 32'(n), 32'd48);
    check("done_high", 32'(done_d), 32'd1);
    check("done_busy", 32'(busy_d), 32'd1);
    check("done_en", 32'(en_d), 32'd0);
    tick();
    check("done_pulse", 32'(done_d), 32'd0);
    check("idle_busy", 32'(busy_d), 32'd0);
  endtask

  // Pulses refresh on the selected instance and records its writes until done.
  task automatic run_capture(input int s, output int n, output int done_at);
    sel = s;
    if (s == 1) ref_s = 1'b1; else ref_w = 1'b1;
    tick();
    ref_s = 1'b0;
    ref_w = 1'b0;
    n = 0;
    done_at = -1;
    for (int cyc = 0; cyc < 300 && done_at < 0; cyc++) begin
      if (m_en && n < 64) begin
        cap_addr[n] = m_addr;
        cap_data[n] = m_data;
        n++;
      end
      if (m_done) done_at = cyc;
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n, done_at;
    string s;

    // reset state
    repeat (2) tick();
    check("rst_addr", 32'(addr_d), 32'h0);
    check("rst_data", 32'(wdata_d), 32'h0);
    check("rst_en", 32'(en_d), 32'h0);
    check("rst_busy", 32'(busy_d), 32'h0);
    check("rst_done", 32'(done_d), 32'h0);
    rst_n = 1'b1;
    tick();

    // plain pass
    data_d = {16'hC0DE, 16'h0000, 16'hFFFF, 16'h1A2F};
    exp_line[0] = "A:0x1A2F    ";
    exp_line[1] = "B:0xFFFF    ";
    exp_line[2] = "C:0x0000    ";
    exp_line[3] = "D:0xC0DE    ";
    ref_d = 1'b1;
    tick();
    ref_d = 1'b0;
    check("first_busy", 32'(busy_d), 32'd1);
    do_pass(-1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("quiet_en", 32'(en_d), 32'd0);
      tick();
    end

    // backpressure on the third character
    ref_d = 1'b1;
    tick();
    ref_d = 1'b0;
    do_pass(2, 1'b0);

    // overlapping refresh requests, reg0 changed mid-pass
    ref_d = 1'b1;
    tick();
    ref_d = 1'b0;
    do_pass(-1, 1'b1);
    check("gap_en", 32'(en_d), 32'd0);
    tick();
    exp_line[0] = "A:0xBEEF    ";
    do_pass(-1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("single_extra_en", 32'(en_d), 32'd0);
      check("single_extra_busy", 32'(busy_d), 32'd0);
      tick();
    end

    // reset during the 10th write
    ref_d = 1'b1;
    tick();
    ref_d = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("pre_rst_addr", 32'(addr_d), 32'h0189);
    rst_n = 1'b0;
    #1;
    check("abort_addr", 32'(addr_d), 32'h0);
    check("abort_data", 32'(wdata_d), 32'h0);
    check("abort_en", 32'(en_d), 32'h0);
    check("abort_busy", 32'(busy_d), 32'h0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("post_rst_en", 32'(en_d), 32'd0);
      tick();
    end

    // skip-unchanged: zero line skipped on first pass
    data_s = {16'h0004, 16'h0002, 16'h0000, 16'h0001};
    run_capture(1, n, done_at);
    check("skip1_count", 32'(n), 32'd36);
    check("skip1_done_at", 32'(done_at), 32'd36);
    check("skip1_addr0", 32'(cap_addr[0]), 32'h0180);
    check("skip1_addr12", 32'(cap_addr[12]), 32'h0380);
    check("skip1_addr24", 32'(cap_addr[24]), 32'h0480);
    check("skip1_data19", 32'(cap_data[19]), 32'h32);

    // only reg2 changes
    data_s[47:32] = 16'h5555;
    run_capture(1, n, done_at);
    check("skip2_count", 32'(n), 32'd12);
    check("skip2_done_at", 32'(done_at), 32'd12);
    s = "C:0x5555    ";
    for (int i = 0; i < 12; i++) begin
      check("skip2_addr", 32'(cap_addr[i]), 32'h0380 + 32'(i));
      check("skip2_data", 32'(cap_data[i]), 32'(s.getc(i)));
    end

    // nothing changed: done right after start
    run_capture(1, n, done_at);
    check("skip3_count", 32'(n), 32'd0);
    check("skip3_done_at", 32'(done_at), 32'd0);

    // 10-bit registers: three digits, zero-extended top nibble
    data_w = {10'h000, 10'h123, 10'h3FF, 10'h2A5};
    exp_line[0] = "A:0x2A5     ";
    exp_line[1] = "B:0x3FF     ";
    exp_line[2] = "C:0x123     ";
    exp_line[3] = "D:0x000     ";
    run_capture(2, n, done_at);
    check("w10_count", 32'(n), 32'd48);
    check("w10_done_at", 32'(done_at), 32'd48);
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 12; c++) begin
        check("w10_addr", 32'(cap_addr[k*12+c]), 32'({7'(3 + 2 * k), 7'(c)}));
        check("w10_data", 32'(cap_data[k*12+c]), 32'(exp_line[k].getc(c)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
